// File: rtl/cpu_regs_wr_arb.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered external writes.
// Optional starvation guard enabled by defining RISC16_WR_ARB_STARVE_GUARD_EN.

package risc16;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int REG_DATA_WIDTH = 16;

    typedef struct packed {
        logic                      wr_en;
        logic [REG_ADDR_WIDTH-1:0] reg_addr;
        logic [REG_DATA_WIDTH-1:0] wr_data;
    } wb_task_t;
endpackage

module cpu_regs_wr_arb
    import risc16::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  wb_task_t                        pipe_task_i,
    output logic                            pipe_stall_o,
    input  logic                            ext_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]       ext_addr_i,
    input  logic [REG_DATA_WIDTH-1:0]       ext_data_i,
    output logic                            ext_ready_o,
    output wb_task_t                        task_o,
    output logic [2**REG_ADDR_WIDTH-1:0]    pend_mask_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt_o
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [REG_ADDR_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] addr_mem_d [FIFO_DEPTH];
    logic [REG_DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
    logic [REG_DATA_WIDTH-1:0] data_mem_d [FIFO_DEPTH];

    logic push;
    logic pop;
    logic empty;
    logic force_grant;

`ifdef RISC16_WR_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_C = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q, starve_d;

    assign force_grant = !rst_i && !empty && (starve_q == STARVE_C);

    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic starve_limit_unused;

    assign starve_limit_unused = (STARVE_LIMIT > 0);
    assign force_grant         = 1'b0;
`endif

    assign empty        = (cnt_q == '0);
    assign ext_ready_o  = !rst_i && (cnt_q < DEPTH_C);
    assign push         = ext_valid_i && ext_ready_o;
    assign pipe_stall_o = force_grant;
    assign fifo_cnt_o   = cnt_q;

    // A forced head beats the pipeline; otherwise the pipeline beats the buffer.
    always_comb begin
        task_o = '0;
        pop    = 1'b0;
        if (!rst_i) begin
            if (force_grant || (!pipe_task_i.wr_en && !empty)) begin
                task_o.wr_en    = 1'b1;
                task_o.reg_addr = addr_mem_q[rd_ptr_q];
                task_o.wr_data  = data_mem_q[rd_ptr_q];
                pop             = 1'b1;
            end else if (pipe_task_i.wr_en) begin
                task_o = pipe_task_i;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            addr_mem_d[wr_ptr_q] = ext_addr_i;
            data_mem_d[wr_ptr_q] = ext_data_i;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Slot i holds a live entry when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        pend_mask_o = '0;
        offset      = '0;
        if (!rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                offset = PTR_W'(i) - rd_ptr_q;
                if (CNT_W'(offset) < cnt_q) begin
                    pend_mask_o[addr_mem_q[i]] = 1'b1;
                end
            end
            if (push) begin
                pend_mask_o[ext_addr_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: tb/tb_cpu_regs_wr_arb.sv
// Scoreboard bench for cpu_regs_wr_arb: a queue-based reference model predicts each
// cycle's status and the ordered stream of register-file writes; a monitor compares.

`timescale 1ns/1ps

module tb_cpu_regs_wr_arb;
    import risc16::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    wb_task_t    pipe_task;
    logic        pipe_stall;
    logic        ext_valid;
    logic [3:0]  ext_addr;
    logic [15:0] ext_data;
    logic        ext_ready;
    wb_task_t    task_out;
    logic [15:0] pend_mask;
    logic [2:0]  fifo_cnt;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    typedef struct {
        logic        chk_full;
        logic        wr_en;
        logic        ready;
        logic        stall;
        logic [2:0]  cnt;
        logic [15:0] mask;
    } exp_t;

    ent_t mq[$];
    int   mwait = 0;
    exp_t exp_q[$];
    ent_t wr_q[$];

    int checks = 0;
    int errors = 0;

    cpu_regs_wr_arb #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pipe_task_i  (pipe_task),
        .pipe_stall_o (pipe_stall),
        .ext_valid_i  (ext_valid),
        .ext_addr_i   (ext_addr),
        .ext_data_i   (ext_data),
        .ext_ready_o  (ext_ready),
        .task_o       (task_out),
        .pend_mask_o  (pend_mask),
        .fifo_cnt_o   (fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic apply_stimulus(input logic r, input logic pwe, input logic [3:0] pa, input logic [15:0] pd,
                                  input logic ev, input logic [3:0] ea, input logic [15:0] ed);
        exp_t e;
        logic ready;
        logic push;
        logic forced;
        logic pop;
        int   size_before;
        @(negedge clk);
        rst                = r;
        pipe_task.wr_en    = pwe;
        pipe_task.reg_addr = pa;
        pipe_task.wr_data  = pd;
        ext_valid          = ev;
        ext_addr           = ea;
        ext_data           = ed;
        e.chk_full = !r;
        e.wr_en    = 1'b0;
        e.ready    = 1'b0;
        e.stall    = 1'b0;
        e.cnt      = 3'd0;
        e.mask     = 16'd0;
        if (r) begin
            exp_q.push_back(e);
            mq.delete();
            mwait = 0;
            return;
        end
        size_before = mq.size();
        ready  = (size_before < DEPTH);
        push   = ev && ready;
`ifdef RISC16_WR_ARB_STARVE_GUARD_EN
        forced = (size_before > 0) && (mwait == LIMIT);
`else
        forced = 1'b0;
`endif
        pop = 1'b0;
        if (forced || (!pwe && size_before > 0)) begin
            wr_q.push_back(mq[0]);
            e.wr_en = 1'b1;
            pop     = 1'b1;
        end else if (pwe) begin
            ent_t pe;
            pe.a = pa;
            pe.d = pd;
            wr_q.push_back(pe);
            e.wr_en = 1'b1;
        end
        foreach (mq[i]) e.mask[mq[i].a] = 1'b1;
        if (push) e.mask[ea] = 1'b1;
        e.ready = ready;
        e.stall = forced;
        e.cnt   = 3'(size_before);
        exp_q.push_back(e);
        if (pop) void'(mq.pop_front());
        if (push) begin
            ent_t ne;
            ne.a = ea;
            ne.d = ed;
            mq.push_back(ne);
        end
        mwait = (pop || size_before == 0) ? 0 : mwait + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    endtask

    // Monitor: per-cycle status checks plus ordered write-stream scoreboard.
    initial begin
        exp_t e;
        ent_t w;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("wr_en", 32'(task_out.wr_en), 32'(e.wr_en));
                check_output("ext_ready", 32'(ext_ready), 32'(e.ready));
                check_output("pipe_stall", 32'(pipe_stall), 32'(e.stall));
                if (e.chk_full) begin
                    check_output("fifo_cnt", 32'(fifo_cnt), 32'(e.cnt));
                    check_output("pend_mask", 32'(pend_mask), 32'(e.mask));
                end
                if (task_out.wr_en === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        check_output("unexpected_write", 32'(1), 32'(0));
                    end else begin
                        w = wr_q.pop_front();
                        check_output("write_addr", 32'(task_out.reg_addr), 32'(w.a));
                        check_output("write_data", 32'(task_out.wr_data), 32'(w.d));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pipe_pct;
        int ext_pct;
        rst       = 1'b1;
        pipe_task = '0;
        ext_valid = 1'b0;
        ext_addr  = '0;
        ext_data  = '0;

        apply_stimulus(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        apply_stimulus(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);

        // Single ext write to R3 with no pipeline traffic.
        apply_stimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h1234);
        idle(2);

        // Fill the buffer while the pipeline writes every cycle; a fifth write is held off.
        for (int i = 1; i <= 5; i++)
            apply_stimulus(1'b0, 1'b1, 4'(8 + i), 16'(16'hA000 + i), 1'b1, 4'(i), 16'(16'h1000 + i));
        for (int i = 0; i < 20; i++)
            apply_stimulus(1'b0, 1'b1, 4'd7, 16'(16'hB000 + i), 1'b1, 4'd5, 16'h1005);
        idle(6);

        // Full buffer, pipeline idle, ext valid held: exercises pointer wrap with push+pop.
        for (int i = 0; i < 4; i++)
            apply_stimulus(1'b0, 1'b1, 4'd2, 16'(16'hC000 + i), 1'b1, 4'(i), 16'(16'h2000 + i));
        for (int i = 0; i < 10; i++)
            apply_stimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'(i + 4), 16'(16'h3000 + i));
        idle(6);

        // Reset with two entries buffered: neither may ever be written.
        apply_stimulus(1'b0, 1'b1, 4'd1, 16'hD000, 1'b1, 4'd6, 16'h4006);
        apply_stimulus(1'b0, 1'b1, 4'd1, 16'hD001, 1'b1, 4'd0, 16'h4000);
        apply_stimulus(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        idle(3);

        // Randomised traffic with varying pipeline and ext loads, occasional resets.
        for (int seg = 0; seg < 6; seg++) begin
            pipe_pct = (seg * 20) % 101;
            ext_pct  = 30 + (seg * 13) % 60;
            for (int i = 0; i < 100; i++) begin
                apply_stimulus($urandom_range(0, 79) == 0,
                               $urandom_range(0, 99) < pipe_pct,
                               4'($urandom_range(0, 15)), 16'($urandom),
                               $urandom_range(0, 99) < ext_pct,
                               4'($urandom_range(0, 15)), 16'($urandom));
            end
        end
        idle(12);

        @(negedge clk);
        #4;
        check_output("pending_expectations", 32'(exp_q.size()), 32'(0));
        check_output("missing_writes", 32'(wr_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
